// File: rtl/ddco_pkg.sv
// Shared definitions for the DDCO arithmetic set: FSM state encoding and default width.
package ddco_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/serial_adder_4bit_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface serial_adder_4bit_if
  import ddco_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout
  );

endinterface

// File: rtl/serial_adder_4bit_full_adder_cell.sv
// Combinational 1-bit full adder; the only arithmetic element of the serial datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: captures A/B/Cin on start, adds LSB-first through one full-adder cell,
// and presents {Cout,Sum} = A + B + Cin with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// RUN   | one sum bit per clock, WIDTH clocks
// DONE  | done pulse for one cycle, result registered
module serial_adder_4bit
  import ddco_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_4bit_if.slave  bus
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_cout;

  full_adder_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;

    case (state_q)
      ST_RUN: begin
        carry_d  = fa_cout;
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The last RUN edge both computes the MSB and publishes the result.
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
          cout_d  = fa_cout;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        // Also covers the unused encoding 2'd3, which behaves as IDLE.
        state_d = ST_IDLE;
        if (bus.start) begin
          state_d  = ST_RUN;
          a_sr_d   = bus.A;
          b_sr_d   = bus.B;
          carry_d  = bus.Cin;
          cnt_d    = '0;
          sum_sr_d = '0;
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Self-checking bench for serial_adder_4bit (WIDTH=4): directed table, corner sequences,
// and a shuffled sweep of all 512 operand combinations against an arithmetic model.
module tb_serial_adder_4bit;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_4bit_if #(.WIDTH(W)) bus ();

  serial_adder_4bit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer addition modulo 2^(W+1).
  function automatic logic [W:0] model_add(input int a, input int b, input int cin);
    int r;
    r = (a + b + cin) % (1 << (W + 1));
    return r[W:0];
  endfunction

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic [3:0] exp_sum, input logic exp_cout);
    logic [3:0] prev_sum;
    int lat, busy_drop, sum_moves;
    bit seen;
    prev_sum = bus.Sum;
    bus.A = a; bus.B = b; bus.Cin = cin; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A = ~a; bus.B = ~b; bus.Cin = ~cin;
    lat = 0; seen = 0; busy_drop = 0; sum_moves = 0;
    while (!seen && lat < 12) begin
      if (bus.done === 1'b1) seen = 1;
      else begin
        if (bus.busy !== 1'b1) busy_drop++;
        if (bus.Sum !== prev_sum) sum_moves++;
        tick();
        lat++;
      end
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'(W));
    check($sformatf("%s busy_gap", tag), 32'(busy_drop), 32'd0);
    check($sformatf("%s sum_early", tag), 32'(sum_moves), 32'd0);
    check($sformatf("%s sum", tag), 32'(bus.Sum), 32'(exp_sum));
    check($sformatf("%s cout", tag), 32'(bus.Cout), 32'(exp_cout));
    tick();
    check($sformatf("%s done_pulse", tag), 32'(bus.done), 32'd0);
    check($sformatf("%s busy_after", tag), 32'(bus.busy), 32'd0);
    check($sformatf("%s sum_held", tag), 32'(bus.Sum), 32'(exp_sum));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones, w, last_done;
    logic [3:0] s_at_done;
    int perm[512];
    logic [8:0] v;
    int a, b, ci, tmp, j, r;
    logic [W:0] exp;

    vecs[0] = '{a: 4'h3, b: 4'h5, cin: 1'b0, sum: 4'h8, cout: 1'b0};
    vecs[1] = '{a: 4'hF, b: 4'h1, cin: 1'b0, sum: 4'h0, cout: 1'b1};
    vecs[2] = '{a: 4'hF, b: 4'hF, cin: 1'b1, sum: 4'hF, cout: 1'b1};
    vecs[3] = '{a: 4'h9, b: 4'h6, cin: 1'b1, sum: 4'h0, cout: 1'b1};
    vecs[4] = '{a: 4'h0, b: 4'h0, cin: 1'b1, sum: 4'h1, cout: 1'b0};
    vecs[5] = '{a: 4'hA, b: 4'h5, cin: 1'b0, sum: 4'hF, cout: 1'b0};
    vecs[6] = '{a: 4'h8, b: 4'h8, cin: 1'b0, sum: 4'h0, cout: 1'b1};
    vecs[7] = '{a: 4'h0, b: 4'h0, cin: 1'b0, sum: 4'h0, cout: 1'b0};

    rst = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    tick(); tick();
    check("reset_outputs", 32'({bus.busy, bus.done, bus.Cout, bus.Sum}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle_c%0d", i), 32'({bus.busy, bus.done, bus.Cout, bus.Sum}), 32'd0);
    end

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

    // Start during RUN must be ignored.
    bus.A = 4'h2; bus.B = 4'h2; bus.Cin = 1'b0; bus.start = 1'b1;
    tick();
    bus.A = 4'h7; bus.B = 4'h7;
    tick(); tick();
    bus.start = 1'b0;
    dones = 0; s_at_done = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) begin dones++; s_at_done = bus.Sum; end
      tick();
    end
    check("ignore done_count", 32'(dones), 32'd1);
    check("ignore sum", 32'(s_at_done), 32'h4);
    check("ignore busy_end", 32'(bus.busy), 32'd0);

    // Reset on the second RUN cycle aborts without a done pulse.
    bus.A = 4'hE; bus.B = 4'h3; bus.Cin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort outputs", 32'({bus.busy, bus.done, bus.Cout, bus.Sum}), 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) dones++;
      tick();
    end
    check("abort no_done", 32'(dones), 32'd0);
    run_op("post_abort", 4'h1, 4'h1, 1'b0, 4'h2, 1'b0);

    // rst and start together: rst wins.
    bus.A = 4'h5; bus.B = 4'h5; bus.start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    check("rst_beats_start busy", 32'(bus.busy), 32'd0);
    tick();
    check("rst_beats_start idle", 32'({bus.busy, bus.done}), 32'd0);

    // Shuffled sweep of all operand combinations with start held high.
    for (int i = 0; i < 512; i++) perm[i] = i;
    for (int i = 511; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    last_done = -1;
    v = perm[0][8:0];
    bus.A = v[8:5]; bus.B = v[4:1]; bus.Cin = v[0]; bus.start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      v = perm[i][8:0];
      a = int'(v[8:5]); b = int'(v[4:1]); ci = int'(v[0]);
      w = 0;
      while (bus.done !== 1'b1 && w < 20) begin tick(); w++; end
      check($sformatf("sweep%0d done", i), 32'(bus.done), 32'd1);
      exp = model_add(a, b, ci);
      check($sformatf("sweep%0d result a=%0h b=%0h c=%0d", i, a, b, ci),
            32'({bus.Cout, bus.Sum}), 32'(exp));
      r = (int'(bus.Sum) - b - ci) & 15;
      check($sformatf("sweep%0d subtract_back", i), 32'(r), 32'(a));
      if (last_done >= 0)
        check($sformatf("sweep%0d spacing", i), 32'(cyc - last_done), 32'(W + 2));
      last_done = cyc;
      if (i < 511) begin
        v = perm[i + 1][8:0];
        bus.A = v[8:5]; bus.B = v[4:1]; bus.Cin = v[0];
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    for (int i = 0; i < 8; i++) tick();
    check("final idle", 32'({bus.busy, bus.done}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
